// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write-port arbiter: pipeline priority, 2-entry MDU FIFO, busy scoreboard
module grf_wb_arbiter (
    input  logic        clk,
    input  logic        RESET,
    input  logic        p_we,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_a3,
    input  logic [31:0] m_wd,
    input  logic [31:0] m_pc,
    input  logic        mark_en,
    input  logic [4:0]  mark_a,
    input  logic [4:0]  rs_a,
    input  logic [4:0]  rt_a,
    output logic        stall,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [1:0]  fifo_cnt
);

    logic [4:0]  a3_q [0:1];
    logic [31:0] wd_q [0:1];
    logic [31:0] pc_q [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  cnt;
    // bit 0 exists only so decode addresses index directly; it is never set
    logic [31:0] busy;
    logic [31:0] busy_nxt;

    logic p_act;
    logic deq;
    logic acc;
    logic enq;

    // A pipeline write to r0 is no request; RESET idles the port entirely
    assign p_act    = !RESET && p_we && (p_a3 != 5'd0);
    // FIFO drains only when the pipeline leaves the port free
    assign deq      = !RESET && !p_act && (cnt != 2'd0);
    assign m_ready  = !RESET && (cnt < 2'd2);
    assign acc      = m_valid && m_ready;
    // Results targeting r0 are accepted but dropped
    assign enq      = acc && (m_a3 != 5'd0);
    assign fifo_cnt = cnt;

    // Decode stalls while any nonzero source register awaits an MDU result
    assign stall = !RESET &&
                   (((rs_a != 5'd0) && busy[rs_a]) || ((rt_a != 5'd0) && busy[rt_a]));

    // Write-port mux: pipeline first, then FIFO head, else idle with zeroed fields
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        grf_pc = 32'd0;
        if (p_act) begin
            grf_we = 1'b1;
            grf_a3 = p_a3;
            grf_wd = p_wd;
            grf_pc = p_pc;
        end else if (deq) begin
            grf_we = 1'b1;
            grf_a3 = a3_q[rd_ptr];
            grf_wd = wd_q[rd_ptr];
            grf_pc = pc_q[rd_ptr];
        end
    end

    // FIFO storage, 1-bit wrapping pointers and occupancy count
    always_ff @(posedge clk) begin
        if (RESET) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (enq) begin
                a3_q[wr_ptr] <= m_a3;
                wd_q[wr_ptr] <= m_wd;
                pc_q[wr_ptr] <= m_pc;
                wr_ptr       <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            if (enq && !deq) begin
                cnt <= cnt + 2'd1;
            end else if (deq && !enq) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    // Scoreboard update: dequeue clears, mark sets afterwards so the set wins a collision
    always_comb begin
        busy_nxt = busy;
        if (deq) begin
            busy_nxt[a3_q[rd_ptr]] = 1'b0;
        end
        if (mark_en && (mark_a != 5'd0)) begin
            busy_nxt[mark_a] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register, cleared by reset
    always_ff @(posedge clk) begin
        if (RESET) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed self-checking bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        RESET;
    logic        p_we;
    logic [4:0]  p_a3;
    logic [31:0] p_wd;
    logic [31:0] p_pc;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;
    logic        mark_en;
    logic [4:0]  mark_a;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic        stall;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [1:0]  fifo_cnt;

    int checks = 0;
    int errors = 0;

    grf_wb_arbiter dut (
        .clk(clk), .RESET(RESET),
        .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
        .mark_en(mark_en), .mark_a(mark_a), .rs_a(rs_a), .rt_a(rt_a), .stall(stall),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs are then driven at the falling edge and sampled 1 later
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mres(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        m_valid = v; m_a3 = a; m_wd = d; m_pc = pc;
    endtask

    task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        p_we = we; p_a3 = a; p_wd = d; p_pc = 32'h4000;
    endtask

    initial begin
        RESET = 1'b1;
        pipe(1'b1, 5'd3, 32'h1234);
        mres(1'b0, 5'd0, 32'd0, 32'd0);
        mark_en = 1'b0; mark_a = 5'd0; rs_a = 5'd0; rt_a = 5'd0;
        tick();
        tick();
        #1;
        // reset state, pipeline request ignored
        check("rst_we", grf_we, 0);
        check("rst_ready", m_ready, 0);
        check("rst_stall", stall, 0);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_a3", grf_a3, 0);

        // drain: a3=5 wd=0x11
        RESET = 1'b0;
        pipe(1'b0, 5'd0, 32'd0);
        mres(1'b1, 5'd5, 32'h11, 32'h100);
        #1;
        check("drn_ready", m_ready, 1);
        check("drn_nobypass", grf_we, 0);
        tick();
        mres(1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        check("drn_cnt1", fifo_cnt, 1);
        check("drn_we", grf_we, 1);
        check("drn_a3", grf_a3, 5);
        check("drn_wd", grf_wd, 32'h11);
        check("drn_pc", grf_pc, 32'h100);
        tick();
        #1;
        check("drn_cnt0", fifo_cnt, 0);
        check("drn_idle", grf_we, 0);

        // priority: FIFO holds a3=3, pipeline writes r7 for 2 cycles
        mres(1'b1, 5'd3, 32'h33, 32'h200);
        tick();
        mres(1'b0, 5'd0, 32'd0, 32'd0);
        pipe(1'b1, 5'd7, 32'hAA);
        #1;
        check("pri_c1_a3", grf_a3, 7);
        check("pri_c1_wd", grf_wd, 32'hAA);
        tick();
        #1;
        check("pri_c2_a3", grf_a3, 7);
        check("pri_c2_cnt", fifo_cnt, 1);
        tick();
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("pri_c3_a3", grf_a3, 3);
        check("pri_c3_wd", grf_wd, 32'h33);
        tick();
        #1;
        check("pri_cnt0", fifo_cnt, 0);

        // back-pressure with a continuously writing pipeline
        pipe(1'b1, 5'd8, 32'h88);
        mres(1'b1, 5'd10, 32'h1, 32'h300);
        tick();
        mres(1'b1, 5'd11, 32'h2, 32'h304);
        tick();
        mres(1'b1, 5'd12, 32'h3, 32'h308);
        #1;
        check("bp_cnt2", fifo_cnt, 2);
        check("bp_ready0", m_ready, 0);
        check("bp_pipe", grf_a3, 8);
        tick();
        #1;
        check("bp_held_cnt", fifo_cnt, 2);
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("bp_head_a3", grf_a3, 10);
        check("bp_head_wd", grf_wd, 32'h1);
        check("bp_ready_still0", m_ready, 0);
        tick();
        #1;
        check("bp_ready1", m_ready, 1);
        check("bp_cnt1", fifo_cnt, 1);
        check("bp_2nd_a3", grf_a3, 11);
        tick();
        mres(1'b0, 5'd0, 32'd0, 32'd0);
        pipe(1'b1, 5'd0, 32'hDEAD);
        #1;
        check("bp_simul_cnt", fifo_cnt, 1);
        check("bp_r0_noreq_a3", grf_a3, 12);
        check("bp_3rd_wd", grf_wd, 32'h3);
        tick();
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("bp_empty", fifo_cnt, 0);

        // result targeting r0 is consumed and discarded
        mres(1'b1, 5'd0, 32'h55, 32'h400);
        tick();
        mres(1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        check("r0_cnt", fifo_cnt, 0);
        check("r0_we", grf_we, 0);

        // scoreboard on r9
        mark_en = 1'b1; mark_a = 5'd9; rs_a = 5'd9;
        #1;
        check("sb_pre_stall", stall, 0);
        tick();
        mark_en = 1'b0;
        #1;
        check("sb_rs_stall", stall, 1);
        rs_a = 5'd0;
        #1;
        check("sb_rs0", stall, 0);
        rt_a = 5'd9;
        #1;
        check("sb_rt_stall", stall, 1);
        pipe(1'b1, 5'd9, 32'h99);
        tick();
        #1;
        check("sb_pipe_noclear", stall, 1);
        pipe(1'b0, 5'd0, 32'd0);
        mres(1'b1, 5'd9, 32'h90, 32'h500);
        tick();
        mres(1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        check("sb_draining_a3", grf_a3, 9);
        check("sb_stall_during", stall, 1);
        tick();
        #1;
        check("sb_cleared", stall, 0);
        rt_a = 5'd0;

        // same-cycle mark and clear on r4
        mark_en = 1'b1; mark_a = 5'd4;
        tick();
        mark_en = 1'b0;
        mres(1'b1, 5'd4, 32'h44, 32'h600);
        tick();
        mres(1'b0, 5'd0, 32'd0, 32'd0);
        mark_en = 1'b1; mark_a = 5'd4; rs_a = 5'd4;
        #1;
        check("col_drain_a3", grf_a3, 4);
        check("col_stall_pre", stall, 1);
        tick();
        mark_en = 1'b0;
        #1;
        check("col_stall_post", stall, 1);
        check("col_cnt0", fifo_cnt, 0);

        // reset mid-operation
        rs_a = 5'd6;
        mark_en = 1'b1; mark_a = 5'd6;
        pipe(1'b1, 5'd1, 32'h10);
        mres(1'b1, 5'd13, 32'hD, 32'h700);
        tick();
        mark_en = 1'b0;
        mres(1'b1, 5'd14, 32'hE, 32'h704);
        tick();
        mres(1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        check("mr_cnt2", fifo_cnt, 2);
        check("mr_stall6", stall, 1);
        RESET = 1'b1;
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("mr_in_we", grf_we, 0);
        check("mr_in_stall", stall, 0);
        check("mr_in_ready", m_ready, 0);
        tick();
        RESET = 1'b0;
        #1;
        check("mr_cnt0", fifo_cnt, 0);
        check("mr_stall0", stall, 0);
        check("mr_no_write", grf_we, 0);
        rs_a = 5'd4;
        #1;
        check("mr_busy4_clr", stall, 0);
        pipe(1'b1, 5'd2, 32'h22);
        #1;
        check("mr_first_we", grf_we, 1);
        check("mr_first_a3", grf_a3, 2);
        tick();
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("mr_lost", grf_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
